// File: rtl/sti_pkg.sv
// Shared definitions for the STI command loader: FSM states, command word
// layout, serializer length codes and a helper that unpacks a command word.
package sti_pkg;

  // Width of one packed command word in the command memory
  localparam int CMD_W = 22;

  // Bit positions inside a command word
  localparam int CMD_LAST     = 21;
  localparam int CMD_LOW      = 20;
  localparam int CMD_MSB      = 19;
  localparam int CMD_FILL     = 18;
  localparam int CMD_LEN_MSB  = 17;
  localparam int CMD_LEN_LSB  = 16;
  localparam int CMD_DATA_MSB = 15;
  localparam int CMD_DATA_LSB = 0;

  // Serializer burst length codes carried in pi_length
  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  // Loader sequencing states
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_END,
    S_DONE
  } state_t;

  // Decoded view of one command word
  typedef struct packed {
    logic        last;
    logic        low;
    logic        msb;
    logic        fill;
    logic [1:0]  length;
    logic [15:0] data;
  } cmd_t;

  // Split a raw memory word into its named fields
  function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] word);
    cmd_t c;
    c.last   = word[CMD_LAST];
    c.low    = word[CMD_LOW];
    c.msb    = word[CMD_MSB];
    c.fill   = word[CMD_FILL];
    c.length = word[CMD_LEN_MSB:CMD_LEN_LSB];
    c.data   = word[CMD_DATA_MSB:CMD_DATA_LSB];
    return c;
  endfunction

endpackage

// File: rtl/sti_cmd_loader.sv
// Command loader feeding the STI/DAC serializer. Walks the command memory
// from address 0, presents each command on pi_* with a one-cycle load pulse,
// waits for the serializer burst (so_valid) to finish, and signals pi_end
// once the final command has been serialized or a timeout aborts the run.
module sti_cmd_loader
  import sti_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_rd,
  input  logic [CMD_W-1:0]  cmd_rdata,
  input  logic              so_valid,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  output logic              busy,
  output logic              err
);

  // The timeout counter only has to reach TIMEOUT-1; it saturates at all-ones.
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t            state;
  logic [CNT_W-1:0]  to_cnt;
  logic              last_q;
  cmd_t              rd_cmd;
  logic              final_cmd;
  logic              timeout_hit;

  // Decode the memory word so the fetch path reads by field name
  always_comb begin
    rd_cmd = unpack_cmd(cmd_rdata);
  end

  // A command ends the run if flagged last or if it sits at the top address,
  // because the address never wraps back to 0 within a run.
  always_comb begin
    final_cmd   = last_q || (cmd_addr == ADDR_MAX);
    timeout_hit = (to_cnt >= CNT_LAST);
  end

  // Sequencer with all outputs registered alongside the state transitions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_addr  <= '0;
      cmd_rd    <= 1'b0;
      load      <= 1'b0;
      pi_data   <= '0;
      pi_length <= LEN_8;
      pi_fill   <= 1'b0;
      pi_msb    <= 1'b0;
      pi_low    <= 1'b0;
      pi_end    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      last_q    <= 1'b0;
      to_cnt    <= '0;
    end else begin
      cmd_rd <= 1'b0;
      load   <= 1'b0;
      pi_end <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err      <= 1'b0;
            cmd_addr <= '0;
            cmd_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          pi_data   <= rd_cmd.data;
          pi_length <= rd_cmd.length;
          pi_fill   <= rd_cmd.fill;
          pi_msb    <= rd_cmd.msb;
          pi_low    <= rd_cmd.low;
          last_q    <= rd_cmd.last;
          load      <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (so_valid) begin
            state <= S_WAIT_DONE;
          end else if (timeout_hit) begin
            err    <= 1'b1;
            pi_end <= 1'b1;
            state  <= S_END;
          end else if (to_cnt != CNT_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!so_valid) begin
            if (final_cmd) begin
              pi_end <= 1'b1;
              state  <= S_END;
            end else begin
              cmd_addr <= cmd_addr + 1'b1;
              state    <= S_GAP;
            end
          end
        end
        S_GAP: begin
          cmd_rd <= 1'b1;
          state  <= S_FETCH;
        end
        S_END: begin
          busy  <= 1'b0;
          state <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sti_cmd_loader.sv
// Directed bench for sti_cmd_loader: a synchronous command memory and a
// simple serializer stand-in (so_valid high for 8/16/24/32 cycles after load)
// surround the loader; a second instance with ADDR_W=2 covers the top address.
module tb_sti_cmd_loader;

  logic        clk = 1'b0;
  logic        reset, start, start_w;
  logic [4:0]  cmd_addr;
  logic [1:0]  cmd_addr_w;
  logic        cmd_rd, cmd_rd_w;
  logic [21:0] cmd_rdata, cmd_rdata_w;
  logic        so_valid, so_valid_w;
  logic        load, load_w;
  logic [15:0] pi_data, pi_data_w;
  logic [1:0]  pi_length, pi_length_w;
  logic        pi_fill, pi_msb, pi_low, pi_fill_w, pi_msb_w, pi_low_w;
  logic        pi_end, pi_end_w, busy, busy_w, err, err_w;

  logic [21:0] mem   [0:31];
  logic [21:0] mem_w [0:3];
  logic        ser_enable;
  int          ser_cnt, ser_cnt_w;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  sti_cmd_loader #(.ADDR_W(5), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_addr(cmd_addr), .cmd_rd(cmd_rd),
    .cmd_rdata(cmd_rdata), .so_valid(so_valid), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .busy(busy), .err(err)
  );

  sti_cmd_loader #(.ADDR_W(2), .TIMEOUT(8)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .cmd_addr(cmd_addr_w), .cmd_rd(cmd_rd_w),
    .cmd_rdata(cmd_rdata_w), .so_valid(so_valid_w), .load(load_w), .pi_data(pi_data_w),
    .pi_length(pi_length_w), .pi_fill(pi_fill_w), .pi_msb(pi_msb_w), .pi_low(pi_low_w),
    .pi_end(pi_end_w), .busy(busy_w), .err(err_w)
  );

  // Synchronous command memories, one-cycle read latency
  always @(posedge clk) begin
    if (cmd_rd) cmd_rdata <= mem[cmd_addr];
    if (cmd_rd_w) cmd_rdata_w <= mem_w[cmd_addr_w];
  end

  // Serializer stand-ins: busy for 8*(length+1) cycles starting the cycle after load
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      so_valid <= 1'b0; ser_cnt <= 0;
    end else if (load && ser_enable) begin
      so_valid <= 1'b1; ser_cnt <= (int'(pi_length) + 1) * 8;
    end else if (ser_cnt > 1) begin
      ser_cnt <= ser_cnt - 1;
    end else begin
      so_valid <= 1'b0; ser_cnt <= 0;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      so_valid_w <= 1'b0; ser_cnt_w <= 0;
    end else if (load_w) begin
      so_valid_w <= 1'b1; ser_cnt_w <= (int'(pi_length_w) + 1) * 8;
    end else if (ser_cnt_w > 1) begin
      ser_cnt_w <= ser_cnt_w - 1;
    end else begin
      so_valid_w <= 1'b0; ser_cnt_w <= 0;
    end
  end

  function automatic logic [21:0] mk_cmd(input logic last, input logic low, input logic msb,
                                         input logic fill, input logic [1:0] len,
                                         input logic [15:0] data);
    return {last, low, msb, fill, len, data};
  endfunction

  // Pulse start on the main instance; returns at the negedge after the sampling edge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({load, pi_end, busy, err, cmd_rd} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {load, pi_end, busy, err, cmd_rd});
    end
    checks++;
    if (cmd_addr !== 5'd0 || pi_data !== 16'h0) begin
      fails++; $display("[TB] FAIL reset_data: addr %0h data %0h expected 0 0", cmd_addr, pi_data);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_rd !== 1'b0) begin
      fails++; $display("[TB] FAIL idle_no_start: busy %b cmd_rd %b expected 0 0", busy, cmd_rd);
    end
  endtask

  task automatic test_single_cmd();
    int t_load = -1, t_fall = -1, t_end = -1, n_end = 0, unstable = 0;
    logic seen_high = 1'b0;
    logic [20:0] fields = '0;
    mem[0] = mk_cmd(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'hA55A);
    pulse_start();
    for (int t = 1; t <= 30; t++) begin
      if (t == 1) begin
        checks++;
        if (cmd_rd !== 1'b1 || cmd_addr !== 5'd0 || busy !== 1'b1) begin
          fails++; $display("[TB] FAIL single_fetch: rd %b addr %0d busy %b expected 1 0 1", cmd_rd, cmd_addr, busy);
        end
      end
      if (load && t_load < 0) begin
        t_load = t; fields = {pi_data, pi_length, pi_fill, pi_msb, pi_low};
      end
      if (so_valid) begin
        seen_high = 1'b1;
        if (pi_data !== 16'hA55A) unstable++;
      end else if (seen_high && t_fall < 0) t_fall = t;
      if (pi_end) begin n_end++; t_end = t; end
      @(negedge clk);
    end
    checks++;
    if (t_load !== 3) begin
      fails++; $display("[TB] FAIL single_latency: load at cycle %0d expected 3", t_load);
    end
    checks++;
    if (fields !== {16'hA55A, 2'b00, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("[TB] FAIL single_fields: got %h expected %h", fields, {16'hA55A, 2'b00, 3'b001});
    end
    checks++;
    if (unstable !== 0) begin
      fails++; $display("[TB] FAIL single_hold: %0d unstable cycles expected 0", unstable);
    end
    checks++;
    if (t_end !== 13 || t_fall !== 12 || n_end !== 1) begin
      fails++; $display("[TB] FAIL single_end: pi_end at %0d (x%0d) fall at %0d expected 13 x1 fall 12", t_end, n_end, t_fall);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      fails++; $display("[TB] FAIL single_done: busy %b err %b expected 0 0", busy, err);
    end
  endtask

  task automatic test_multi_cmd();
    logic [20:0] exp_f [3];
    logic [20:0] cur;
    int load_t [3];
    int n_load = 0, n_fetch = 0, n_end = 0, addr_bad = 0, field_bad = 0, unstable = 0, fetch_bad = 0;
    mem[0] = mk_cmd(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 16'h1234);
    mem[1] = mk_cmd(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 16'hBEEF);
    mem[2] = mk_cmd(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0F0F);
    exp_f[0] = {16'h1234, 2'b01, 1'b0, 1'b0, 1'b0};
    exp_f[1] = {16'hBEEF, 2'b10, 1'b1, 1'b1, 1'b0};
    exp_f[2] = {16'h0F0F, 2'b11, 1'b0, 1'b1, 1'b1};
    load_t = '{default: 0};
    pulse_start();
    for (int t = 1; t <= 100; t++) begin
      cur = {pi_data, pi_length, pi_fill, pi_msb, pi_low};
      if (cmd_rd) begin
        if (cmd_addr !== 5'(n_fetch)) fetch_bad++;
        n_fetch++;
      end
      if (load) begin
        if (n_load < 3) begin
          load_t[n_load] = t;
          if (cmd_addr !== 5'(n_load)) addr_bad++;
          if (cur !== exp_f[n_load]) field_bad++;
        end
        n_load++;
      end
      if (so_valid && n_load >= 1 && n_load <= 3 && cur !== exp_f[n_load-1]) unstable++;
      if (pi_end) n_end++;
      @(negedge clk);
    end
    checks++;
    if (n_load !== 3 || n_end !== 1) begin
      fails++; $display("[TB] FAIL multi_count: loads %0d ends %0d expected 3 1", n_load, n_end);
    end
    checks++;
    if (load_t[1] - load_t[0] !== 21 || load_t[2] - load_t[1] !== 29) begin
      fails++; $display("[TB] FAIL multi_spacing: %0d %0d expected 21 29", load_t[1] - load_t[0], load_t[2] - load_t[1]);
    end
    checks++;
    if (addr_bad !== 0 || fetch_bad !== 0 || n_fetch !== 3) begin
      fails++; $display("[TB] FAIL multi_addr: bad %0d/%0d fetches %0d expected 0/0 3", addr_bad, fetch_bad, n_fetch);
    end
    checks++;
    if (field_bad !== 0 || unstable !== 0) begin
      fails++; $display("[TB] FAIL multi_fields: bad %0d unstable %0d expected 0 0", field_bad, unstable);
    end
    checks++;
    if (cmd_addr !== 5'd2 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL multi_final: addr %0d busy %b expected 2 0", cmd_addr, busy);
    end
  endtask

  task automatic test_timeout();
    int t_err = -1, t_end = -1, n_load = 0;
    logic busy_after = 1'b1;
    logic got_end = 1'b0;
    ser_enable = 1'b0;
    mem[0] = mk_cmd(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h5555);
    pulse_start();
    for (int t = 1; t <= 20; t++) begin
      if (err && t_err < 0) t_err = t;
      if (pi_end) t_end = t;
      if (load) n_load++;
      if (t == 13) busy_after = busy;
      @(negedge clk);
    end
    checks++;
    if (t_err !== 12 || t_end !== 12) begin
      fails++; $display("[TB] FAIL timeout_err: err at %0d pi_end at %0d expected 12 12", t_err, t_end);
    end
    checks++;
    if (n_load !== 1 || busy_after !== 1'b0) begin
      fails++; $display("[TB] FAIL timeout_stop: loads %0d busy %b expected 1 0", n_load, busy_after);
    end
    checks++;
    if (err !== 1'b1) begin
      fails++; $display("[TB] FAIL timeout_sticky: err %b expected 1", err);
    end
    ser_enable = 1'b1;
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("[TB] FAIL timeout_restart: err %b busy %b expected 0 1", err, busy);
    end
    for (int t = 0; t < 60 && !got_end; t++) begin
      if (pi_end) got_end = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (got_end !== 1'b1 || err !== 1'b0) begin
      fails++; $display("[TB] FAIL timeout_rerun: pi_end seen %b err %b expected 1 0", got_end, err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int load_t [2];
    int n_load = 0, n_fetch = 0, t_end = -1, n_end = 0;
    mem[0] = mk_cmd(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h00F1);
    mem[1] = mk_cmd(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h00F2);
    load_t = '{default: 0};
    pulse_start();
    for (int t = 1; t <= 35; t++) begin
      if (load) begin
        if (n_load < 2) load_t[n_load] = t;
        n_load++;
      end
      if (cmd_rd) n_fetch++;
      if (pi_end) begin n_end++; t_end = t; end
      start = (t == 8);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n_load !== 2 || load_t[0] !== 3 || load_t[1] !== 16) begin
      fails++; $display("[TB] FAIL ignore_loads: %0d loads at %0d,%0d expected 2 at 3,16", n_load, load_t[0], load_t[1]);
    end
    checks++;
    if (n_fetch !== 2 || n_end !== 1 || t_end !== 26) begin
      fails++; $display("[TB] FAIL ignore_end: fetches %0d ends %0d at %0d expected 2 1 at 26", n_fetch, n_end, t_end);
    end
    checks++;
    if (cmd_addr !== 5'd1) begin
      fails++; $display("[TB] FAIL ignore_addr: addr %0d expected 1", cmd_addr);
    end
  endtask

  task automatic test_reset_mid();
    int n_end = 0, n_busy = 0;
    pulse_start();
    repeat (6) @(negedge clk);
    checks++;
    if (so_valid !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("[TB] FAIL midreset_setup: so_valid %b busy %b expected 1 1", so_valid, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({load, pi_end, busy, cmd_rd} !== 4'b0 || cmd_addr !== 5'd0 || pi_data !== 16'h0) begin
      fails++; $display("[TB] FAIL midreset_clear: ctrl %b addr %0d data %h expected 0000 0 0",
                        {load, pi_end, busy, cmd_rd}, cmd_addr, pi_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (pi_end) n_end++;
      if (busy) n_busy++;
      @(negedge clk);
    end
    checks++;
    if (n_end !== 0 || n_busy !== 0) begin
      fails++; $display("[TB] FAIL midreset_quiet: pi_end %0d busy %0d cycles expected 0 0", n_end, n_busy);
    end
  endtask

  task automatic test_addr_wrap();
    int n_load = 0, n_fetch = 0, n_end = 0, addr_bad = 0, data_bad = 0, fetch_bad = 0;
    for (int i = 0; i < 4; i++) mem_w[i] = mk_cmd(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'hC000 + 16'(i));
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    for (int t = 1; t <= 80; t++) begin
      if (cmd_rd_w) begin
        if (cmd_addr_w !== 2'(n_fetch)) fetch_bad++;
        n_fetch++;
      end
      if (load_w) begin
        if (cmd_addr_w !== 2'(n_load)) addr_bad++;
        if (pi_data_w !== 16'hC000 + 16'(n_load)) data_bad++;
        n_load++;
      end
      if (pi_end_w) n_end++;
      @(negedge clk);
    end
    checks++;
    if (n_load !== 4 || n_fetch !== 4 || fetch_bad !== 0) begin
      fails++; $display("[TB] FAIL wrap_count: loads %0d fetches %0d badfetch %0d expected 4 4 0", n_load, n_fetch, fetch_bad);
    end
    checks++;
    if (addr_bad !== 0 || data_bad !== 0) begin
      fails++; $display("[TB] FAIL wrap_order: addr bad %0d data bad %0d expected 0 0", addr_bad, data_bad);
    end
    checks++;
    if (n_end !== 1 || cmd_addr_w !== 2'd3 || busy_w !== 1'b0) begin
      fails++; $display("[TB] FAIL wrap_end: ends %0d addr %0d busy %b expected 1 3 0", n_end, cmd_addr_w, busy_w);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_w = 1'b0; ser_enable = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem_w[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_cmd();
    test_multi_cmd();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_addr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
